// File: rtl/vmask_accum_pkg.sv
// Shared definitions for the vector mask accumulator: widths, FSM states and
// the written-bit to byte-enable reduction.
package vmask_accum_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int BEAT_BITS  = 8;
  localparam int ADDR_WIDTH = 32;
  localparam int OFF_WIDTH  = 6;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } acc_state_t;

  function automatic logic [BE_WIDTH-1:0] wr_to_be(input logic [DATA_WIDTH-1:0] wr);
    logic [BE_WIDTH-1:0] be;
    for (int k = 0; k < BE_WIDTH; k++) begin
      be[k] = |wr[8*k +: 8];
    end
    return be;
  endfunction

endpackage

// File: rtl/vmask_accum_merge.sv
// Combinational merge of one compare beat into a mask word; bits landing past
// the top of the word are dropped, later writers overwrite earlier ones.
module vmask_accum_merge
  import vmask_accum_pkg::*;
(
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] acc_data,
  input  logic [DATA_WIDTH-1:0] acc_wr,
  input  logic [BEAT_BITS-1:0]  in_mask,
  input  logic [BEAT_BITS-1:0]  in_be,
  input  logic [OFF_WIDTH-1:0]  in_off,
  output logic [DATA_WIDTH-1:0] new_data,
  output logic [DATA_WIDTH-1:0] new_wr
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    new_data = clear ? '0 : acc_data;
    new_wr   = clear ? '0 : acc_wr;
    for (int j = 0; j < BEAT_BITS; j++) begin
      logic [OFF_WIDTH:0] pos;
      pos = {1'b0, in_off} + (OFF_WIDTH+1)'(j);
      if (in_be[j] && !pos[OFF_WIDTH]) begin
        new_data[pos[OFF_WIDTH-1:0]] = in_mask[j];
        new_wr[pos[OFF_WIDTH-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vmask_accum.sv
// Accumulates multi-beat mask-compare results into one 64-bit mask word and
// issues a single byte-enabled register-file write per word.
module vmask_accum
  import vmask_accum_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [BEAT_BITS-1:0]  in_mask,
  input  logic [BEAT_BITS-1:0]  in_be,
  input  logic [OFF_WIDTH-1:0]  in_off,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [BE_WIDTH-1:0]   out_be
);

  acc_state_t            state;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [DATA_WIDTH-1:0] acc_wr;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] new_data;
  logic [DATA_WIDTH-1:0] new_wr;
  logic                  out_free;
  logic                  accept;
  logic                  addr_match;

  assign out_free   = !out_valid || out_ready;
  assign in_ready   = out_free && (state != DRAIN);
  assign accept     = in_valid && in_ready;
  assign addr_match = (in_addr == acc_addr);

  // Only a same-address beat in ACCUM merges; every other accept starts a fresh word.
  vmask_accum_merge u_merge (
    .clear    (state != ACCUM || !addr_match),
    .acc_data (acc_data),
    .acc_wr   (acc_wr),
    .in_mask  (in_mask),
    .in_be    (in_be),
    .in_off   (in_off),
    .new_data (new_data),
    .new_wr   (new_wr)
  );

  // NOTE: sequential state uses non-blocking assignments only; a later assignment
  // in the same edge (an emit) overrides the earlier handshake clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      acc_data  <= '0;
      acc_wr    <= '0;
      acc_addr  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_be    <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        EMPTY: if (accept) begin
          if (in_last) begin
            out_valid <= 1'b1;
            out_addr  <= in_addr;
            out_data  <= new_data & new_wr;
            out_be    <= wr_to_be(new_wr);
            acc_data  <= '0;
            acc_wr    <= '0;
          end else begin
            acc_data <= new_data;
            acc_wr   <= new_wr;
            acc_addr <= in_addr;
            state    <= ACCUM;
          end
        end
        ACCUM: if (accept) begin
          if (addr_match && in_last) begin
            out_valid <= 1'b1;
            out_addr  <= acc_addr;
            out_data  <= new_data & new_wr;
            out_be    <= wr_to_be(new_wr);
            acc_data  <= '0;
            acc_wr    <= '0;
            state     <= EMPTY;
          end else if (addr_match) begin
            acc_data <= new_data;
            acc_wr   <= new_wr;
          end else begin
            out_valid <= 1'b1;
            out_addr  <= acc_addr;
            out_data  <= acc_data & acc_wr;
            out_be    <= wr_to_be(acc_wr);
            acc_data  <= new_data;
            acc_wr    <= new_wr;
            acc_addr  <= in_addr;
            state     <= in_last ? DRAIN : ACCUM;
          end
        end
        DRAIN: if (out_free) begin
          out_valid <= 1'b1;
          out_addr  <= acc_addr;
          out_data  <= acc_data & acc_wr;
          out_be    <= wr_to_be(acc_wr);
          acc_data  <= '0;
          acc_wr    <= '0;
          state     <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_vmask_accum.sv
// Directed bench for vmask_accum: stimulus pushes expected writes into a
// scoreboard queue, a monitor pops and compares each completed output handshake.
module tb_vmask_accum;
  import vmask_accum_pkg::*;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]   be;
  } wr_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr = '0;
  logic [BEAT_BITS-1:0]  in_mask = '0;
  logic [BEAT_BITS-1:0]  in_be = '0;
  logic [OFF_WIDTH-1:0]  in_off = '0;
  logic                  in_last = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic [BE_WIDTH-1:0]   out_be;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  vmask_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_mask   (in_mask),
    .in_be     (in_be),
    .in_off    (in_off),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_be    (out_be)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expect_wr(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d,
                           input logic [BE_WIDTH-1:0] b);
    wr_t w;
    w.addr = a; w.data = d; w.be = b;
    exp_q.push_back(w);
  endtask

  // Drives one beat, waits (bounded) for acceptance, returns cycles spent stalled.
  task automatic send(input logic [ADDR_WIDTH-1:0] a, input logic [OFF_WIDTH-1:0] off,
                      input logic [BEAT_BITS-1:0] m, input logic [BEAT_BITS-1:0] be,
                      input logic last, output int stall);
    in_addr = a; in_off = off; in_mask = m; in_be = be; in_last = last;
    in_valid = 1'b1;
    stall = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stall++;
      if (stall > 50) begin
        checks++; errors++;
        $display("FAIL accept_timeout: beat at addr 0x%0h never accepted", a);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h be 0x%0h with nothing expected",
                 out_addr, out_data, out_be);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", 64'(out_addr), 64'(w.addr));
        check("wr_data", out_data, w.data);
        check("wr_be",   64'(out_be), 64'(w.be));
      end
    end
  end

  initial begin
    int st;
    logic [DATA_WIDTH-1:0] held_data;

    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  out_data, 64'd0);
    check("rst_out_addr",  64'(out_addr), 64'd0);
    check("rst_out_be",    64'(out_be), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Single flushing beat, visible right after the accepting edge.
    expect_wr(32'h40, 64'hA5, 8'h01);
    send(32'h40, 6'd0, 8'hA5, 8'hFF, 1'b1, st);
    check("single_latency", 64'(out_valid), 64'd1);
    idle(2);

    // Eight beats build one full word; only the last flushes.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) expect_wr(32'h10, 64'h0807060504030201, 8'hFF);
      send(32'h10, 6'(8 * i), 8'(i + 1), 8'hFF, i == 7, st);
      check("stream_stall", 64'(st), 64'd0);
    end
    idle(2);

    // Address change: old word emitted, new word drains one cycle later.
    expect_wr(32'h10, 64'h0F, 8'h01);
    send(32'h10, 6'd0, 8'h0F, 8'h0F, 1'b0, st);
    expect_wr(32'h18, 64'hF0, 8'h01);
    send(32'h18, 6'd0, 8'hF0, 8'hF0, 1'b1, st);
    check("drain_in_ready", 64'(in_ready), 64'd0);
    idle(1);
    check("after_drain_in_ready", 64'(in_ready), 64'd1);
    idle(2);

    // Output stall: held stable, upstream blocked, then same-cycle accept.
    out_ready = 1'b0;
    expect_wr(32'h20, 64'h3C, 8'h01);
    send(32'h20, 6'd0, 8'h3C, 8'hFF, 1'b1, st);
    held_data = out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_addr", 64'(out_addr), 64'h20);
      check("stall_data", out_data, held_data);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    expect_wr(32'h28, 64'hF0, 8'h01);
    send(32'h28, 6'd4, 8'hFF, 8'h0F, 1'b1, st);
    check("release_stall", 64'(st), 64'd0);
    idle(2);

    // Beat straddling the top of the word: upper bits dropped.
    expect_wr(32'h30, 64'hF000000000000000, 8'h80);
    send(32'h30, 6'd60, 8'hFF, 8'hFF, 1'b1, st);
    idle(2);

    // All-zero enables still produce an (empty) write.
    expect_wr(32'h38, 64'h0, 8'h00);
    send(32'h38, 6'd0, 8'hFF, 8'h00, 1'b1, st);
    idle(2);

    // Asynchronous reset mid-ACCUM with a pending output: everything discarded.
    out_ready = 1'b0;
    send(32'h50, 6'd0, 8'h11, 8'hFF, 1'b0, st);
    send(32'h58, 6'd0, 8'h22, 8'hFF, 1'b0, st);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_data", out_data, 64'd0);
    #7 rst = 1'b0;
    out_ready = 1'b1;
    idle(5);
    check("post_rst_valid", 64'(out_valid), 64'd0);

    expect_wr(32'h40, 64'hA5, 8'h01);
    send(32'h40, 6'd0, 8'hA5, 8'hFF, 1'b1, st);
    check("post_rst_latency", 64'(out_valid), 64'd1);
    idle(4);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
